adc_sample_averager: RTL and testbench



---
 rtl/adc_pkg.sv | 19 +
 rtl/adc_sample_averager.sv | 107 ++++++++++
 tb/tb_adc_sample_averager.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared sample types for the ADC capture path
// and its downstream consumers.
package adc_pkg;

  localparam int SAMPLE_W = 12;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = 12'hFFF;

  function automatic sample_t smin(sample_t a, sample_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic sample_t smax(sample_t a, sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_sample_averager.sv
// Windowed mean/min/max of the ADC sample stream
// with a one-slot valid/ready result register.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [SAMPLE_W-1:0] In_data,
  input  logic                In_valid,
  output logic [SAMPLE_W-1:0] Out_data,
  output logic [SAMPLE_W-1:0] Out_min,
  output logic [SAMPLE_W-1:0] Out_max,
  output logic                Out_valid,
  input  logic                Out_ready,
  output logic                Overrun
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  // N = 1 still needs a one-bit counter stuck at 0
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  sample_t          min_q;
  sample_t          max_q;

  sample_t          data_q;
  sample_t          omin_q;
  sample_t          omax_q;
  logic             valid_q;
  logic             ovr_q;

  logic [ACC_W-1:0] sum;
  sample_t          win_min;
  sample_t          win_max;
  sample_t          mean;
  logic             done;
  logic             slot_open;
  logic             load;
  logic             drop;

  // Window arithmetic including the current sample
  always_comb begin
    sum       = acc_q + ACC_W'(In_data);
    win_min   = smin(min_q, In_data);
    win_max   = smax(max_q, In_data);
    mean      = sample_t'(sum >> AVG_LOG2);
    done      = In_valid && (cnt_q == LAST);
    slot_open = !valid_q || Out_ready;
    load      = done && slot_open;
    drop      = done && !slot_open;
  end

  // Running accumulator, count and extremes
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      min_q <= SAMPLE_MAX;
      max_q <= '0;
    end else if (In_valid) begin
      if (done) begin
        acc_q <= '0;
        cnt_q <= '0;
        min_q <= SAMPLE_MAX;
        max_q <= '0;
      end else begin
        acc_q <= sum;
        cnt_q <= cnt_q + CNT_W'(1);
        min_q <= win_min;
        max_q <= win_max;
      end
    end
  end

  // Result slot: load when free or being drained
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_q  <= '0;
      omin_q  <= '0;
      omax_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= drop;
      if (load) begin
        data_q  <= mean;
        omin_q  <= win_min;
        omax_q  <= win_max;
        valid_q <= 1'b1;
      end else if (Out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign Out_data  = data_q;
  assign Out_min   = omin_q;
  assign Out_max   = omax_q;
  assign Out_valid = valid_q;
  assign Overrun   = ovr_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench: four averagers with
// AVG_LOG2 = 0..3 driven one at a time.
module tb_adc_sample_averager;

  typedef struct packed {
    logic [11:0] d;
    logic [11:0] mn;
    logic [11:0] mx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] in_data   [4];
  logic        in_valid  [4];
  logic        out_ready [4];
  logic [11:0] out_data  [4];
  logic [11:0] out_min   [4];
  logic [11:0] out_max   [4];
  logic        out_valid [4];
  logic        overrun   [4];

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];
  exp_t e;

  int          m_sum [4];
  int          m_cnt [4];
  logic [11:0] m_min [4];
  logic [11:0] m_max [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    adc_sample_averager #(.AVG_LOG2(g)) u_dut (
      .Clk       (clk),
      .Rst       (rst),
      .In_data   (in_data[g]),
      .In_valid  (in_valid[g]),
      .Out_data  (out_data[g]),
      .Out_min   (out_min[g]),
      .Out_max   (out_max[g]),
      .Out_valid (out_valid[g]),
      .Out_ready (out_ready[g]),
      .Overrun   (overrun[g])
    );
  end

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
      m_min[i] = 12'hFFF;
      m_max[i] = 12'h000;
    end
    exp_q.delete();
  endtask

  // Reference window model; pushes on completion
  task automatic model_push(int d, logic [11:0] s);
    int n;
    exp_t x;
    n = 1 << d;
    m_sum[d] += int'(s);
    if (s < m_min[d]) m_min[d] = s;
    if (s > m_max[d]) m_max[d] = s;
    m_cnt[d]++;
    if (m_cnt[d] == n) begin
      x.d  = 12'(m_sum[d] / n);
      x.mn = m_min[d];
      x.mx = m_max[d];
      exp_q.push_back(x);
      m_sum[d] = 0;
      m_cnt[d] = 0;
      m_min[d] = 12'hFFF;
      m_max[d] = 12'h000;
    end
  endtask

  // One strobe; returns at the negedge after capture
  task automatic feed(int d, logic [11:0] s);
    in_data[d]  = s;
    in_valid[d] = 1'b1;
    model_push(d, s);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid[i] !== 1'b0 || overrun[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got v=%b o=%b want 0/0",
                 i, out_valid[i], overrun[i]);
      end
      checks++;
      if (out_data[i] !== 0 || out_min[i] !== 0 ||
          out_max[i] !== 0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %0d/%0d/%0d want 0/0/0",
                 i, out_data[i], out_min[i], out_max[i]);
      end
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    out_ready[2] = 1'b1;
    feed(2, 100);
    feed(2, 200);
    feed(2, 300);
    feed(2, 401);
    checks++;
    if (out_valid[2] !== 1'b1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL basic_valid: got v=%b q=%0d want 1/1",
               out_valid[2], exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (out_data[2] !== e.d || out_min[2] !== e.mn ||
          out_max[2] !== e.mx) begin
        errors++;
        $display("FAIL basic_stats: got %0d/%0d/%0d want %0d/%0d/%0d",
                 out_data[2], out_min[2], out_max[2], e.d, e.mn, e.mx);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: got v=%b want 0", out_valid[2]);
    end
  endtask

  task automatic test_full_scale();
    out_ready[2] = 1'b1;
    repeat (4) feed(2, 12'hFFF);
    checks++;
    e = exp_q.pop_front();
    if (out_valid[2] !== 1'b1 || out_data[2] !== e.d ||
        out_min[2] !== e.mn || out_max[2] !== e.mx) begin
      errors++;
      $display("FAIL full_scale: got v=%b %0d/%0d/%0d want 1 %0d/%0d/%0d",
               out_valid[2], out_data[2], out_min[2], out_max[2],
               e.d, e.mn, e.mx);
    end
    repeat (4) feed(2, 12'h000);
    checks++;
    e = exp_q.pop_front();
    if (out_valid[2] !== 1'b1 || out_data[2] !== e.d ||
        out_min[2] !== e.mn || out_max[2] !== e.mx) begin
      errors++;
      $display("FAIL zero_scale: got v=%b %0d/%0d/%0d want 1 %0d/%0d/%0d",
               out_valid[2], out_data[2], out_min[2], out_max[2],
               e.d, e.mn, e.mx);
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    out_ready[1] = 1'b0;
    feed(1, 10);
    feed(1, 20);
    e = exp_q.pop_front();
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== e.d ||
        out_min[1] !== e.mn || out_max[1] !== e.mx) begin
      errors++;
      $display("FAIL hold_first: got v=%b %0d/%0d/%0d want 1 %0d/%0d/%0d",
               out_valid[1], out_data[1], out_min[1], out_max[1],
               e.d, e.mn, e.mx);
    end
    feed(1, 30);
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== e.d) begin
      errors++;
      $display("FAIL hold_stable: got v=%b %0d want 1 %0d",
               out_valid[1], out_data[1], e.d);
    end
    feed(1, 50);
    // this window is dropped, so it never reaches the output
    void'(exp_q.pop_back());
    checks++;
    if (overrun[1] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got %b want 1", overrun[1]);
    end
    checks++;
    if (out_data[1] !== e.d || out_min[1] !== e.mn ||
        out_max[1] !== e.mx) begin
      errors++;
      $display("FAIL overrun_keep: got %0d/%0d/%0d want %0d/%0d/%0d",
               out_data[1], out_min[1], out_max[1], e.d, e.mn, e.mx);
    end
    @(negedge clk);
    checks++;
    if (overrun[1] !== 1'b0) begin
      errors++;
      $display("FAIL overrun_once: got %b want 0", overrun[1]);
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    checks++;
    if (out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL late_accept: got v=%b want 0", out_valid[1]);
    end
  endtask

  task automatic test_back_to_back_accept();
    out_ready[1] = 1'b0;
    feed(1, 10);
    feed(1, 20);
    e = exp_q.pop_front();
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== e.d) begin
      errors++;
      $display("FAIL held15: got v=%b %0d want 1 %0d",
               out_valid[1], out_data[1], e.d);
    end
    feed(1, 2);
    out_ready[1] = 1'b1;
    feed(1, 4);
    e = exp_q.pop_front();
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== e.d ||
        out_min[1] !== e.mn || out_max[1] !== e.mx) begin
      errors++;
      $display("FAIL swap_load: got v=%b %0d/%0d/%0d want 1 %0d/%0d/%0d",
               out_valid[1], out_data[1], out_min[1], out_max[1],
               e.d, e.mn, e.mx);
    end
    checks++;
    if (overrun[1] !== 1'b0) begin
      errors++;
      $display("FAIL swap_no_ovr: got %b want 0", overrun[1]);
    end
    @(negedge clk);
    out_ready[1] = 1'b0;
    checks++;
    if (out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL swap_drain: got v=%b want 0", out_valid[1]);
    end
  endtask

  task automatic test_mid_reset();
    out_ready[3] = 1'b1;
    feed(3, 999);
    feed(3, 999);
    do_reset();
    checks++;
    if (out_valid[3] !== 1'b0 || out_data[3] !== 0 ||
        out_min[3] !== 0 || out_max[3] !== 0) begin
      errors++;
      $display("FAIL midrst_out: got v=%b %0d/%0d/%0d want 0 0/0/0",
               out_valid[3], out_data[3], out_min[3], out_max[3]);
    end
    repeat (7) feed(3, 8);
    checks++;
    if (out_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: got v=%b want 0", out_valid[3]);
    end
    feed(3, 8);
    e = exp_q.pop_front();
    checks++;
    if (out_valid[3] !== 1'b1 || out_data[3] !== e.d ||
        out_min[3] !== e.mn || out_max[3] !== e.mx) begin
      errors++;
      $display("FAIL midrst_win: got v=%b %0d/%0d/%0d want 1 %0d/%0d/%0d",
               out_valid[3], out_data[3], out_min[3], out_max[3],
               e.d, e.mn, e.mx);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [11:0] s [3];
    s[0] = 12'd7;
    s[1] = 12'hFFF;
    s[2] = 12'd0;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[0]  = s[i];
      in_valid[0] = 1'b1;
      model_push(0, s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== e.d ||
          out_min[0] !== e.mn || out_max[0] !== e.mx) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b %0d/%0d/%0d want 1 %0d/%0d/%0d",
                 i, out_valid[0], out_data[0], out_min[0], out_max[0],
                 e.d, e.mn, e.mx);
      end
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got q=%0d v=%b want 0/0",
               exp_q.size(), out_valid[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      in_data[i]   = '0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    model_clear();
    test_reset();
    test_basic();
    test_full_scale();
    test_overrun();
    test_back_to_back_accept();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
